// File: rtl/sm_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_mdu_pkg
//  Description : Shared types and constants for the multicycle ALU/MDU.
//  Revision    : 1.0  initial release
// ============================================================================
package sm_mdu_pkg;

    // Operation encoding driven by the core controller
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_ORR  = 3'b011,
        OP_EOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_UDIV = 3'b110,
        OP_SDIV = 3'b111
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // True for the two divide opcodes
    function automatic logic is_div(input op_e o);
        return (o == OP_UDIV) || (o == OP_SDIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_mdu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : sm_mdu_divider
//  Description : Iterative restoring divider, one quotient bit per step.
//                Signed mode divides magnitudes and negates the quotient on
//                the final step so no extra cycle is spent on the fix-up.
//  Revision    : 1.0  initial release
// ============================================================================
module sm_mdu_divider
    import sm_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             last,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        a_mag = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One restoring iteration: shift in next dividend bit, trial-subtract
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
        quotient = neg_q ? (~quo_step + 1'b1) : quo_step;
    end

    // Next-state for the working registers; load wins over step
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        neg_d = neg_q;
        if (load) begin
            rem_d = '0;
            quo_d = a_mag;
            dvs_d = b_mag;
            neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            rem_d = rem_step;
            quo_d = last ? quotient : quo_step;
        end
    end

    // Working register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            neg_q <= neg_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm_mdu_alu.sv
`default_nettype none
// ============================================================================
//  Module      : sm_mdu_alu
//  Description : Registered ALU with single-cycle ADD/SUB/AND/ORR/EOR and
//                iterative MUL/UDIV/SDIV behind a start/ready/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module sm_mdu_alu
    import sm_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             div_zero
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    op_e              op_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] acc_step;
    logic             cnt_last;
    logic             div_load;
    logic             div_step;
    logic             div_last;
    logic [WIDTH-1:0] div_quotient;

    // Pack {N,Z,C,V} from a result and the arithmetic carry/overflow
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_N] = r[WIDTH-1];
        f[FLG_Z] = (r == '0);
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

    assign op_in    = op_e'(op);
    assign cnt_last = (cnt_q == CNT_W'(1));
    assign div_last = (state_q == S_DIV) && cnt_last;

    sm_mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (div_load),
        .step        (div_step),
        .last        (div_last),
        .signed_mode (op_in == OP_SDIV),
        .a           (src_a),
        .b           (src_b),
        .quotient    (div_quotient)
    );

    // Single-cycle datapath evaluated on the live operands at the accepting edge
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_in)
            OP_ADD: begin
                sum     = {1'b0, src_a} + {1'b0, src_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum     = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_ORR:  alu_res = src_a | src_b;
            OP_EOR:  alu_res = src_a ^ src_b;
            default: alu_res = '0;
        endcase
    end

    // Shift-add partial product for the current multiplier bit
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Sequencer next-state, iteration datapath and output register updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        result_d   = result_q;
        flags_d    = flags_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        div_load   = 1'b0;
        div_step   = 1'b0;

        if (flush) begin
            // Abort wins over everything, including a same-cycle start
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op_in == OP_MUL) begin
                            state_d  = S_MUL;
                            cnt_d    = CNT_W'(WIDTH);
                            mcand_d  = src_a;
                            mplier_d = src_b;
                            acc_d    = '0;
                        end else if (is_div(op_in)) begin
                            if (src_b == '0) begin
                                // Divide by zero resolves immediately
                                done_d     = 1'b1;
                                result_d   = '0;
                                flags_d    = mk_flags('0, 1'b0, 1'b0);
                                div_zero_d = 1'b1;
                            end else begin
                                state_d  = S_DIV;
                                cnt_d    = CNT_W'(WIDTH);
                                div_load = 1'b1;
                            end
                        end else begin
                            done_d     = 1'b1;
                            result_d   = alu_res;
                            flags_d    = mk_flags(alu_res, alu_c, alu_v);
                            div_zero_d = 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_last) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        result_d   = acc_step;
                        flags_d    = mk_flags(acc_step, 1'b0, 1'b0);
                        div_zero_d = 1'b0;
                    end
                end
                S_DIV: begin
                    div_step = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_last) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        result_d   = div_quotient;
                        flags_d    = mk_flags(div_quotient, 1'b0, 1'b0);
                        div_zero_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, multiplier and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign flags    = flags_q;
    assign div_zero = div_zero_q;

endmodule
`default_nettype wire
